// File: rtl/store_buffer.sv
// Store buffer: DEPTH-entry FIFO draining committed stores to data memory.
// Define STORE_BUFFER_BYTE_MERGE_EN for per-byte forwarding merge.
module store_buffer #(
   parameter  int DEPTH  = 4,
   parameter  int XLEN   = 32,
   parameter  int ADDR_W = 32,
   localparam int BE_W   = XLEN / 8,
   localparam int PW     = $clog2(DEPTH),
   localparam int CW     = PW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [XLEN-1:0]   st_data,
   input  logic [BE_W-1:0]   st_be,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [BE_W-1:0]   ld_be,
   output logic              fwd_hit,
   output logic [XLEN-1:0]   fwd_data,
   output logic              fwd_stall,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [BE_W-1:0]   mem_be,
   input  logic              mem_ack,
   input  logic              fence_req,
   output logic              fence_done,
   output logic [CW-1:0]     count
);

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_FENCE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [XLEN-1:0]   data_q [DEPTH];
   logic [BE_W-1:0]   be_q   [DEPTH];
   logic [DEPTH-1:0]  vld_q;

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    state_q, state_d;
   logic          push, pop;

   assign st_ready   = (count_q != CW'(DEPTH)) && (state_q == S_RUN);
   assign mem_req    = (count_q != '0);
   assign mem_addr   = addr_q[head_q];
   assign mem_wdata  = data_q[head_q];
   assign mem_be     = be_q[head_q];
   assign fence_done = (state_q == S_DONE);
   assign count      = count_q;

   always_comb begin
      push    = st_valid && st_ready;
      pop     = mem_req && mem_ack;
      head_d  = head_q + PW'(pop);
      tail_d  = tail_q + PW'(push);
      count_d = count_q + CW'(push) - CW'(pop);
      state_d = state_q;
      unique case (state_q)
         S_RUN:   if (fence_req) state_d = S_FENCE;
         S_FENCE: if (count_q == '0) state_d = S_DONE;
         S_DONE:  state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         vld_q   <= '0;
         state_q <= S_RUN;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         state_q <= state_d;
         if (pop) vld_q[head_q] <= 1'b0;
         if (push) vld_q[tail_q] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= st_addr;
         data_q[tail_q] <= st_data;
         be_q[tail_q]   <= st_be;
      end
   end

   logic [PW-1:0]   idx;
   logic            any_q;
   logic [BE_W-1:0] cov;
   logic [XLEN-1:0] fdata;
   logic            covered;

   // Walk oldest to youngest so later matches overwrite earlier ones.
   always_comb begin
      idx   = '0;
      any_q = 1'b0;
      cov   = '0;
      fdata = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if (vld_q[idx] &&
             (((addr_q[idx] ^ ld_addr) & ~ADDR_W'(3)) == '0)) begin
            any_q = 1'b1;
`ifdef STORE_BUFFER_BYTE_MERGE_EN
            for (int b = 0; b < BE_W; b++) begin
               if (be_q[idx][b]) begin
                  cov[b]          = 1'b1;
                  fdata[8*b +: 8] = data_q[idx][8*b +: 8];
               end
            end
`else
            cov   = be_q[idx];
            fdata = data_q[idx];
`endif
         end
      end
   end

   assign covered   = ((ld_be & ~cov) == '0);
   assign fwd_hit   = ld_valid && any_q && covered;
   assign fwd_stall = ld_valid && any_q && !covered;
   assign fwd_data  = fdata;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue model plus directed vectors.
// Build with STORE_BUFFER_BYTE_MERGE_EN to cover the merge variant.
module tb_store_buffer;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } ent_t;

   logic        clk, rst;
   logic        st_valid, st_ready;
   logic [31:0] st_addr, st_data;
   logic [3:0]  st_be;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic [3:0]  ld_be;
   logic        fwd_hit, fwd_stall;
   logic [31:0] fwd_data;
   logic        mem_req, mem_ack;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        fence_req, fence_done;
   logic [2:0]  count;

   store_buffer #(.DEPTH(DEPTH), .XLEN(32), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_ready(st_ready),
      .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
      .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
      .fence_req(fence_req), .fence_done(fence_done),
      .count(count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Model: queue of pending stores, fence pending flag, done pulse flag.
   ent_t q[$];
   bit   m_init = 1'b0;
   bit   m_fence = 1'b0;
   bit   m_done = 1'b0;

   always @(posedge clk) begin : model
      bit   run, push, pop;
      ent_t e;
      if (rst) begin
         q.delete();
         m_fence <= 1'b0;
         m_done  <= 1'b0;
         m_init  <= 1'b1;
      end else if (m_init) begin
         run  = !m_fence && !m_done;
         push = st_valid && run && (q.size() < DEPTH);
         pop  = mem_ack && (q.size() != 0);
         if (m_done) m_done <= 1'b0;
         else if (m_fence) begin
            if (q.size() == 0) begin
               m_fence <= 1'b0;
               m_done  <= 1'b1;
            end
         end else if (fence_req) m_fence <= 1'b1;
         if (pop) void'(q.pop_front());
         if (push) begin
            e.addr = st_addr;
            e.data = st_data;
            e.be   = st_be;
            q.push_back(e);
         end
      end
   end

   always @(negedge clk) begin : compare
      bit          any, eh, es, f;
      logic [3:0]  cov;
      logic [31:0] ed, mask;
      if (m_init) begin
         chk("count", 32'(count), q.size());
         chk("st_ready", 32'(st_ready),
             32'((q.size() < DEPTH) && !m_fence && !m_done));
         chk("mem_req", 32'(mem_req), 32'(q.size() != 0));
         if (q.size() != 0) begin
            chk("mem_addr", mem_addr, q[0].addr);
            chk("mem_wdata", mem_wdata, q[0].data);
            chk("mem_be", 32'(mem_be), 32'(q[0].be));
         end
         chk("fence_done", 32'(fence_done), 32'(m_done));
         any = 1'b0;
         cov = '0;
         ed  = '0;
         for (int k = q.size() - 1; k >= 0; k--) begin
            if (q[k].addr[31:2] == ld_addr[31:2]) begin
`ifdef STORE_BUFFER_BYTE_MERGE_EN
               any = 1'b1;
`else
               if (!any) begin
                  any = 1'b1;
                  cov = q[k].be;
                  ed  = q[k].data;
               end
`endif
            end
         end
`ifdef STORE_BUFFER_BYTE_MERGE_EN
         for (int b = 0; b < 4; b++) begin
            f = 1'b0;
            for (int k = q.size() - 1; k >= 0; k--) begin
               if (!f && q[k].addr[31:2] == ld_addr[31:2] && q[k].be[b]) begin
                  f = 1'b1;
                  cov[b] = 1'b1;
                  ed[8*b +: 8] = q[k].data[8*b +: 8];
               end
            end
         end
`endif
         eh = ld_valid && any && ((ld_be & ~cov) == 4'd0);
         es = ld_valid && any && !eh;
         for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{ld_be[b]}};
         chk("fwd_hit", 32'(fwd_hit), 32'(eh));
         chk("fwd_stall", 32'(fwd_stall), 32'(es));
         if (eh) chk("fwd_data", fwd_data & mask, ed & mask);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      st_be    = be;
      step();
      st_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      st_valid = 0; st_addr = 0; st_data = 0; st_be = 0;
      ld_valid = 0; ld_addr = 0; ld_be = 0;
      mem_ack = 0; fence_req = 0;
      step(); step();
      rst = 1'b0;
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_st_ready", 32'(st_ready), 1);

      enq(32'h100, 32'hDEADBEEF, 4'hF);
      ld_valid = 1; ld_addr = 32'h100; ld_be = 4'hF;
      #1;
      chk("t1_hit", 32'(fwd_hit), 1);
      chk("t1_data", fwd_data, 32'hDEADBEEF);
      chk("t1_stall", 32'(fwd_stall), 0);
      chk("t1_mem_req", 32'(mem_req), 1);
      chk("t1_mem_addr", mem_addr, 32'h100);
      mem_ack = 1; step(); mem_ack = 0;
      #1;
      chk("t1_count0", 32'(count), 0);
      chk("t1_hit_gone", 32'(fwd_hit), 0);

      enq(32'h200, 32'h11111111, 4'hF);
      enq(32'h200, 32'h22222222, 4'hF);
      ld_addr = 32'h200;
      #1;
      chk("t2_youngest", fwd_data, 32'h22222222);
      chk("t2_wdata0", mem_wdata, 32'h11111111);
      chk("t2_count2", 32'(count), 2);
      mem_ack = 1; step();
      #1;
      chk("t2_wdata1", mem_wdata, 32'h22222222);
      chk("t2_count1", 32'(count), 1);
      step(); mem_ack = 0;
      #1;
      chk("t2_count0", 32'(count), 0);

      enq(32'h300, 32'h11223344, 4'hC);
      enq(32'h300, 32'h5566AABB, 4'h3);
      ld_addr = 32'h300; ld_be = 4'hF;
      #1;
`ifdef STORE_BUFFER_BYTE_MERGE_EN
      chk("t3_merge_hit", 32'(fwd_hit), 1);
      chk("t3_merge_data", fwd_data, 32'h1122AABB);
      chk("t3_merge_stall", 32'(fwd_stall), 0);
`else
      chk("t3_partial_hit", 32'(fwd_hit), 0);
      chk("t3_partial_stall", 32'(fwd_stall), 1);
`endif
      ld_be = 4'h3;
      #1;
      chk("t3_low_hit", 32'(fwd_hit), 1);
      chk("t3_low_data", {16'h0, fwd_data[15:0]}, 32'h0000AABB);
      ld_addr = 32'h304;
      #1;
      chk("t3_miss_hit", 32'(fwd_hit), 0);
      chk("t3_miss_stall", 32'(fwd_stall), 0);
      mem_ack = 1; step(); step(); mem_ack = 0;
      ld_valid = 0;

      st_valid = 1; st_be = 4'hF;
      for (int i = 0; i < 4; i++) begin
         st_addr = 32'h400 + 32'(4 * i);
         st_data = 32'hA0 + 32'(i);
         step();
      end
      st_addr = 32'h500; st_data = 32'hB0;
      #1;
      chk("t4_full_ready", 32'(st_ready), 0);
      chk("t4_full_count", 32'(count), 4);
      mem_ack = 1; step();
      #1;
      chk("t4_no_enq_count", 32'(count), 3);
      chk("t4_head", mem_wdata, 32'hA1);
      for (int i = 0; i < 6; i++) begin
         st_addr = 32'h500 + 32'(4 * i);
         st_data = 32'hB0 + 32'(i);
         step();
      end
      #1;
      chk("t4_wrap_head", mem_wdata, 32'hB3);
      chk("t4_wrap_count", 32'(count), 3);
      st_valid = 0;
      step(); step(); step();
      mem_ack = 0;
      #1;
      chk("t4_drained", 32'(count), 0);

      for (int i = 0; i < 3; i++) enq(32'h700 + 32'(4 * i), 32'hC0 + 32'(i), 4'hF);
      fence_req = 1; step(); fence_req = 0;
      st_valid = 1; st_addr = 32'h800; st_data = 32'hDD;
      #1;
      chk("t5_fence_ready", 32'(st_ready), 0);
      mem_ack = 1; step(); step(); step(); mem_ack = 0;
      #1;
      chk("t5_count0", 32'(count), 0);
      chk("t5_done_early", 32'(fence_done), 0);
      step();
      chk("t5_done", 32'(fence_done), 1);
      chk("t5_done_ready", 32'(st_ready), 0);
      st_valid = 0;
      step();
      chk("t5_done_pulse", 32'(fence_done), 0);
      chk("t5_run_ready", 32'(st_ready), 1);
      fence_req = 1; step(); fence_req = 0;
      chk("t5e_fence", 32'(fence_done), 0);
      step();
      chk("t5e_done", 32'(fence_done), 1);
      step();
      chk("t5e_clear", 32'(fence_done), 0);

      enq(32'h900, 32'h12345678, 4'hF);
      enq(32'h904, 32'h9ABCDEF0, 4'hF);
      ld_valid = 1; ld_addr = 32'h900; ld_be = 4'hF;
      #1;
      chk("t6_pre_req", 32'(mem_req), 1);
      chk("t6_pre_hit", 32'(fwd_hit), 1);
      rst = 1; step(); rst = 0;
      chk("t6_count", 32'(count), 0);
      chk("t6_mem_req", 32'(mem_req), 0);
      chk("t6_hit", 32'(fwd_hit), 0);
      step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Parametrised store buffer between the MEM stage and the data-memory port. It generalises single-entry store-data forwarding to a DEPTH-entry FIFO.
- Committed stores are queued and drained to memory through a req/ack handshake.
- Loads search the buffer combinationally for store-to-load forwarding. The youngest matching entry wins, and partial overlaps produce a stall.
- A fence mode drains the buffer completely and then signals completion.

Parameters:
DEPTH, 4, number of entries (power of two, >=2)
XLEN, 32, data width in bits
ADDR_W, 32, byte-address width
BE_W, XLEN/8, byte-enable width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
st_valid  in  1  store enqueue request
st_ready  out  1  buffer can accept a store
st_addr  in  ADDR_W  store byte address (word-aligned; low bits ignored)
st_data  in  XLEN  store data, already lane-aligned
st_be  in  BE_W  store byte enables
ld_valid  in  1  load lookup request
ld_addr  in  ADDR_W  load byte address (word-aligned compare)
ld_be  in  BE_W  bytes requested by the load
fwd_hit  out  1  load is fully satisfied from the buffer
fwd_data  out  XLEN  forwarded data (bytes outside ld_be undefined)
fwd_stall  out  1  load overlaps the buffer but cannot be forwarded
mem_req  out  1  drain request for the head entry
mem_addr  out  ADDR_W  head entry address
mem_wdata  out  XLEN  head entry data
mem_be  out  BE_W  head entry byte enables
mem_ack  in  1  memory accepted the head entry
fence_req  in  1  request a full drain
fence_done  out  1  one-cycle pulse when the fence has completed
count  out  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Storage:
  - Circular FIFO with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a registered count.
  - A per-entry valid bit is set on enqueue and cleared on pop.
- Reset (synchronous):
  - head=tail=0, count=0, all valid bits=0, state=RUN, fence_done=0.
  - mem_req=0 and fwd_hit=fwd_stall=0 from the first cycle after the reset edge.
  - Reset asserted mid-drain discards all entries; an outstanding mem_req drops the cycle after the reset edge.
- Enqueue:
  - st_ready = (count != DEPTH) && state==RUN.
  - An entry is written at the edge where st_valid && st_ready.
  - Full is judged on the registered count: when full, a same-cycle mem_ack does not admit a new store.
- Drain:
  - mem_req = (count != 0); mem_addr, mem_wdata and mem_be come from the head entry and stay stable until mem_ack.
  - On mem_req && mem_ack: head increments and count decrements at that edge.
  - mem_ack without mem_req is ignored.
  - A simultaneous enqueue and pop leaves count unchanged.
- Latency: a store enqueued into an empty buffer at edge N drives mem_req=1 in the cycle after edge N. Back-to-back acks drain one entry per cycle.
- Forwarding (combinational, valid entries only):
  - An entry matches when addr[ADDR_W-1:2]==ld_addr[ADDR_W-1:2].
  - A store being enqueued in the same cycle is NOT searched.
  - The head entry remains searchable during its ack cycle.
  - Let Y be the youngest matching entry, searched from tail-1 backwards to head with wrap-around.
  - If Y exists and (ld_be & ~Y.be)==0: fwd_hit=1, fwd_data=Y.data.
  - If Y exists and does not cover ld_be: fwd_stall=1, fwd_hit=0.
  - If there is no match: fwd_hit=fwd_stall=0.
  - Both outputs are gated by ld_valid.
- FSM states:
  - RUN --fence_req--> FENCE.
  - FENCE --(count==0)--> DONE.
  - DONE --unconditional--> RUN.
  - fence_done=1 only in DONE, so it pulses exactly one cycle.
  - st_ready=0 in FENCE and DONE.
  - fence_req while empty: FENCE is held for one cycle, and fence_done pulses 2 cycles after the request edge.
  - fence_req is ignored outside RUN.
- Width rules: count compares to DEPTH at full width; pointer arithmetic wraps without a separate full flag.

Optional Feature:
- Macro: STORE_BUFFER_BYTE_MERGE_EN.
- Defined:
  - Forwarding merges per byte: for each byte in ld_be, take that lane from the youngest matching entry whose be covers that byte.
  - fwd_hit=1 if every requested byte is covered by some matching entry.
  - fwd_stall=1 only if at least one entry matches and some requested byte is uncovered.
- Undefined: youngest-entry-only rule as in Behaviour.

Test Plan:
- Enqueue to 0x100 (data 0xDEADBEEF, be 0xF), hold mem_ack=0, load 0x100 be 0xF -> fwd_hit=1, fwd_data=0xDEADBEEF, fwd_stall=0, mem_req=1, mem_addr=0x100.
- Enqueue 0x200/0x11111111/0xF, then 0x200/0x22222222/0xF; load 0x200 -> fwd_data=0x22222222. Ack twice -> mem_wdata 0x11111111 then 0x22222222, count 2->1->0.
- Enqueue 0x300 be 0x3; load 0x300 be 0xF -> fwd_stall=1, fwd_hit=0. With BYTE_MERGE_EN, add an older 0x300 be 0xC entry -> fwd_hit=1 with merged lanes.
- Fill DEPTH=4 entries with mem_ack=0 -> st_ready=0, count=4. Assert mem_ack and st_valid together -> no enqueue that cycle, count=3. Continue 6 enqueue/ack cycles past pointer wrap -> FIFO order preserved.
- Load 3 entries, pulse fence_req -> st_ready=0 throughout. Ack each entry -> fence_done pulses exactly one cycle after count hits 0, then st_ready=1. fence_req when empty -> fence_done 2 cycles after the request edge.
- Load 2 entries, assert rst during mem_req -> next cycle count=0, mem_req=0, fwd_hit=0 for a load to the previously buffered address.
